asym_ram_read_streamer: RTL and testbench

//   Read-side sequencer for the write-wider asymmetric SDP RAM.

---
 rtl/asym_ram_read_streamer.sv | 179 +++++++++++++++++
 tb/tb_asym_ram_read_streamer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asym_ram_read_streamer.sv
// asym_ram_read_streamer
// Read-side sequencer for a write-wider asymmetric simple-dual-port RAM.
// It accepts a (base, length) job, drives the narrow read port (enaB/addrB),
// captures doB one cycle after each read, and presents the words as a
// valid/ready stream. A 3-entry output FIFO and a credit counter give full
// backpressure while sustaining one word per cycle.

module asym_ram_read_streamer #(
    parameter int WIDTHB     = 4,
    parameter int ADDRWIDTHB = 10,
    parameter int LENWIDTH   = 11
) (
    input  logic                  clkB,
    input  logic                  rstB,
    input  logic                  start,
    input  logic [ADDRWIDTHB-1:0] base_addr,
    input  logic [LENWIDTH-1:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  enaB,
    output logic [ADDRWIDTHB-1:0] addrB,
    input  logic [WIDTHB-1:0]     doB,
    output logic [WIDTHB-1:0]     m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    // Read issue bookkeeping
    logic [LENWIDTH-1:0]   r_remaining;   // reads still to be issued
    logic [ADDRWIDTHB-1:0] r_addr;        // next address to issue
    logic                  r_enaB;
    logic [ADDRWIDTHB-1:0] r_addrB;
    logic                  r_cap;         // doB carries data for a read issued last cycle
    logic                  r_done;

    // Credits: FIFO occupancy plus reads whose data has not landed yet
    logic [1:0]            r_cnt;
    logic [1:0]            w_cnt_next;

    // Output FIFO, entry 0 is the head
    logic [WIDTHB-1:0]     r_fifo      [3];
    logic [WIDTHB-1:0]     w_fifo_next [3];
    logic [1:0]            r_occ;
    logic [1:0]            w_occ_next;
    logic [1:0]            w_wr_idx;

    logic                  w_pop;
    logic                  w_issue;
    logic                  w_load;
    logic                  w_done_next;
    logic [ADDRWIDTHB-1:0] w_issue_addr;

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign enaB    = r_enaB;
    assign addrB   = r_addrB;
    assign m_valid = (r_occ != 2'd0);
    assign m_data  = r_fifo[0];

    assign w_pop      = m_valid & m_ready;
    assign w_cnt_next = r_cnt + 2'(w_issue) - 2'(w_pop);
    assign w_occ_next = r_occ + 2'(r_cap) - 2'(w_pop);
    // A landing word goes behind whatever survives this cycle's pop
    assign w_wr_idx   = r_occ - 2'(w_pop);

    // State register
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clkB) begin
        if (rstB) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic, read-issue decision and done generation
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_load       = 1'b0;
        w_done_next  = 1'b0;
        w_issue_addr = r_addr;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        // First read goes out with the job acceptance itself
                        w_issue      = 1'b1;
                        w_load       = 1'b1;
                        w_issue_addr = base_addr;
                        w_state_next = S_RUN;
                    end else begin
                        w_done_next  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (r_remaining == '0) begin
                    w_state_next = S_DRAIN;
                end else if ((r_cnt != 2'd3) || w_pop) begin
                    // A credit is free now, or the head leaves this cycle
                    w_issue = 1'b1;
                end
            end
            S_DRAIN: begin
                // Only the word being popped is still owed: job complete
                if (w_pop && (r_cnt == 2'd1)) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FIFO next contents: shift on pop, then place the landing word
    always_comb begin
        w_fifo_next = r_fifo;
        if (w_pop) begin
            w_fifo_next[0] = r_fifo[1];
            w_fifo_next[1] = r_fifo[2];
        end
        if (r_cap) begin
            case (w_wr_idx)
                2'd0:    w_fifo_next[0] = doB;
                2'd1:    w_fifo_next[1] = doB;
                default: w_fifo_next[2] = doB;
            endcase
        end
    end

    // Read port, address walk, credit counter and FIFO registers
    always_ff @(posedge clkB) begin
        if (rstB) begin
            r_enaB      <= 1'b0;
            r_addrB     <= '0;
            r_cap       <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
            r_addr      <= '0;
            r_cnt       <= 2'd0;
            r_occ       <= 2'd0;
            // NOTE: the FIFO storage is reset too because its head drives m_data, which must read 0 after reset.
            for (int i = 0; i < 3; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            r_enaB <= w_issue;
            if (w_issue) begin
                r_addrB <= w_issue_addr;
            end
            r_cap  <= r_enaB;
            r_done <= w_done_next;
            if (w_load) begin
                r_remaining <= length - LENWIDTH'(1);
                r_addr      <= base_addr + ADDRWIDTHB'(1);
            end else if (w_issue) begin
                r_remaining <= r_remaining - LENWIDTH'(1);
                r_addr      <= r_addr + ADDRWIDTHB'(1);
            end
            r_cnt  <= w_cnt_next;
            r_occ  <= w_occ_next;
            r_fifo <= w_fifo_next;
        end
    end

endmodule

// File: tb/tb_asym_ram_read_streamer.sv
// tb_asym_ram_read_streamer
// Directed bench: narrow-port RAM model with 1-cycle registered read, a
// negedge monitor logging reads/handshakes/done pulses with cycle numbers,
// and hand-computed expectations per job.

module tb_asym_ram_read_streamer;

    logic        clkB;
    logic        rstB;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        busy;
    logic        done;
    logic        enaB;
    logic [9:0]  addrB;
    logic [3:0]  doB;
    logic [3:0]  m_data;
    logic        m_valid;
    logic        m_ready;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rdy_mode = 0;   // 0: always ready, 1: pattern 1,0,0 repeating

    logic [3:0] mem [0:1023];

    // Monitor logs
    logic [3:0] hs_data [$];
    int         hs_cyc  [$];
    int         ena_addr[$];
    int         ena_cyc [$];
    int         done_cyc[$];
    int         n_issued     = 0;
    int         n_accepted   = 0;
    int         max_out      = 0;
    int         n_valid_cyc  = 0;
    int         stall_viol   = 0;
    int         outside_viol = 0;
    logic       prev_stall   = 1'b0;
    logic [3:0] prev_data    = 4'h0;

    asym_ram_read_streamer #(
        .WIDTHB    (4),
        .ADDRWIDTHB(10),
        .LENWIDTH  (11)
    ) dut (
        .clkB     (clkB),
        .rstB     (rstB),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .enaB     (enaB),
        .addrB    (addrB),
        .doB      (doB),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );

    initial clkB = 1'b0;
    always #5 clkB = ~clkB;

    always @(posedge clkB) cyc <= cyc + 1;

    // Narrow read port of the RAM: registered read
    always @(posedge clkB) begin
        if (enaB) doB <= mem[addrB];
    end

    // Downstream ready generator
    always @(posedge clkB) begin
        #1;
        if (rdy_mode == 1) m_ready = ((cyc % 3) == 0);
        else               m_ready = 1'b1;
    end

    // Monitor, sampled mid-cycle
    always @(negedge clkB) begin
        if (enaB) begin
            ena_addr.push_back(int'(addrB));
            ena_cyc.push_back(cyc);
            n_issued++;
            if (n_issued - n_accepted > max_out) max_out = n_issued - n_accepted;
        end
        if (m_valid && m_ready) begin
            hs_data.push_back(m_data);
            hs_cyc.push_back(cyc);
            n_accepted++;
        end
        if (m_valid) n_valid_cyc++;
        if (done) done_cyc.push_back(cyc);
        if (prev_stall && (!m_valid || (m_data != prev_data))) stall_viol++;
        if (m_valid && !busy) outside_viol++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (rstB) n_issued = n_accepted;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkB);
        #1;
    endtask

    task automatic start_job(input int b, input int l, output int t0);
        start     = 1'b1;
        base_addr = 10'(b);
        length    = 11'(l);
        t0        = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_done_seen"}, {31'b0, done}, 32'd1);
    endtask

    task automatic check_words(input string tag, input int ih, input logic [3:0] exp[$]);
        check({tag, "_nhs"}, hs_data.size() - ih, exp.size());
        for (int k = 0; k < exp.size(); k++) begin
            if (ih + k < hs_data.size())
                check($sformatf("%s_d%0d", tag, k), hs_data[ih + k], exp[k]);
            else
                check($sformatf("%s_d%0d_missing", tag, k), 32'hFFFF_FFFF, exp[k]);
        end
    endtask

    task automatic check_addrs(input string tag, input int ie, input int exp[$]);
        check({tag, "_nena"}, ena_addr.size() - ie, exp.size());
        for (int k = 0; k < exp.size(); k++) begin
            if (ie + k < ena_addr.size())
                check($sformatf("%s_a%0d", tag, k), ena_addr[ie + k], exp[k]);
        end
    endtask

    initial begin
        int t0;
        int t1;
        int ih;
        int ie;
        int id;
        int iv;
        int k;

        // RAM contents: default mem[i] = i[3:0]; wide word 0 = 16'hDCBA
        for (int i = 0; i < 1024; i++) mem[i] = 4'(i);
        mem[0] = 4'hA; mem[1] = 4'hB; mem[2] = 4'hC; mem[3] = 4'hD;
        mem[1023] = 4'h7;

        rstB = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
        repeat (3) tick();
        rstB = 1'b0;

        // Reset state
        check("rst_busy",    {31'b0, busy},    0);
        check("rst_done",    {31'b0, done},    0);
        check("rst_enaB",    {31'b0, enaB},    0);
        check("rst_addrB",   {22'b0, addrB},   0);
        check("rst_m_valid", {31'b0, m_valid}, 0);
        check("rst_m_data",  {28'b0, m_data},  0);
        tick();

        // 1: base 0, len 4, always ready
        ih = hs_data.size(); ie = ena_addr.size(); id = done_cyc.size();
        start_job(0, 4, t0);
        check("t1_busy_T1", {31'b0, busy}, 1);
        wait_done("t1", 40);
        check("t1_busy_at_done", {31'b0, busy}, 0);
        tick();
        check_words("t1", ih, '{4'hA, 4'hB, 4'hC, 4'hD});
        for (int j = 0; j < 4; j++)
            if (ih + j < hs_cyc.size()) check($sformatf("t1_cyc%0d", j), hs_cyc[ih + j], t0 + 3 + j);
        check_addrs("t1", ie, '{0, 1, 2, 3});
        if (ie < ena_cyc.size()) check("t1_ena_cyc", ena_cyc[ie], t0 + 1);
        if (id < done_cyc.size()) check("t1_done_cyc", done_cyc[id], t0 + 7);
        else check("t1_done_cyc_missing", 32'hFFFF_FFFF, t0 + 7);

        // 2: same job under backpressure
        rdy_mode = 1;
        tick();
        ih = hs_data.size(); ie = ena_addr.size();
        start_job(0, 4, t0);
        wait_done("t2", 80);
        tick();
        rdy_mode = 0;
        tick();
        check_words("t2", ih, '{4'hA, 4'hB, 4'hC, 4'hD});
        check("t2_nena", ena_addr.size() - ie, 4);
        check("t2_stall_stable", stall_viol, 0);
        check("t2_max_out_le3", {31'b0, (max_out <= 3)}, 1);

        // 3: address wrap
        ih = hs_data.size(); ie = ena_addr.size();
        start_job(1023, 3, t0);
        wait_done("t3", 40);
        tick();
        check_addrs("t3", ie, '{1023, 0, 1});
        check_words("t3", ih, '{4'h7, 4'hA, 4'hB});

        // 4a: zero-length job
        ie = ena_addr.size(); id = done_cyc.size(); iv = n_valid_cyc;
        start_job(0, 0, t0);
        check("t4_busy_len0", {31'b0, busy}, 0);
        wait_done("t4a", 5);
        tick();
        if (id < done_cyc.size()) check("t4_done_cyc", done_cyc[id], t0 + 1);
        else check("t4_done_cyc_missing", 32'hFFFF_FFFF, t0 + 1);
        check("t4_no_ena", ena_addr.size() - ie, 0);
        check("t4_no_valid", n_valid_cyc - iv, 0);

        // 4b: start pulsed while busy is ignored
        ih = hs_data.size(); ie = ena_addr.size();
        start_job(8, 4, t0);
        tick();
        start = 1'b1; base_addr = 10'd20; length = 11'd5;
        tick();
        start = 1'b0;
        wait_done("t4b", 40);
        tick();
        repeat (4) tick();
        check_addrs("t4b", ie, '{8, 9, 10, 11});
        check_words("t4b", ih, '{4'h8, 4'h9, 4'hA, 4'hB});

        // 5: reset mid-job after two words accepted
        ih = hs_data.size(); id = done_cyc.size();
        start_job(0, 8, t0);
        k = 0;
        while (hs_data.size() < ih + 2 && k < 40) begin
            tick();
            k++;
        end
        check("t5_two_accepted", {31'b0, (hs_data.size() >= ih + 2)}, 1);
        rstB = 1'b1;
        tick();
        rstB = 1'b0;
        check("t5_m_valid", {31'b0, m_valid}, 0);
        check("t5_busy",    {31'b0, busy},    0);
        check("t5_enaB",    {31'b0, enaB},    0);
        repeat (6) tick();
        check("t5_no_done", done_cyc.size() - id, 0);
        ih = hs_data.size();
        start_job(4, 2, t0);
        wait_done("t5", 40);
        tick();
        check_words("t5", ih, '{4'h4, 4'h5});

        // 6: back-to-back jobs, second start in the done cycle
        ih = hs_data.size();
        start_job(0, 2, t0);
        wait_done("t6a", 40);
        start_job(4, 2, t1);
        check("t6_enaB",  {31'b0, enaB},  1);
        check("t6_addrB", {22'b0, addrB}, 4);
        wait_done("t6b", 40);
        tick();
        check_words("t6", ih, '{4'hA, 4'hB, 4'h4, 4'h5});

        check("valid_only_in_job", outside_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
